// File: rtl/palette_pkg.sv
// Shared palette types and defaults used by palette_lut and palette_bank_store.
package palette_pkg;

    localparam int PAL_CW = 4;
    localparam logic [3*PAL_CW-1:0] PAL_RST_RGB = 12'h6AF;
    localparam int PAL_TRANSP_IDX = 0;

    typedef struct packed {
        logic [PAL_CW-1:0] red;
        logic [PAL_CW-1:0] green;
        logic [PAL_CW-1:0] blue;
    } rgb_t;

    function automatic rgb_t to_rgb(input logic [3*PAL_CW-1:0] v);
        return rgb_t'(v);
    endfunction

endpackage

// File: rtl/palette_bank_store.sv
// Double-buffered palette storage: writes go to shadow, commit copies shadow to active.
module palette_bank_store
    import palette_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int NUM_BANKS = 4,
    parameter int CW = PAL_CW,
    parameter logic [3*CW-1:0] RST_RGB = PAL_RST_RGB,
    parameter int BW = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             wr_en,
    input  logic [BW-1:0]    wr_bank,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [3*CW-1:0]  wr_rgb,
    input  logic             commit,
    input  logic [BW-1:0]    rd_bank,
    input  logic [IDX_W-1:0] rd_index,
    output logic [3*CW-1:0]  rd_rgb,
    output logic             rd_hit,
    output logic             pending
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [BW:0] NB = (BW+1)'(NUM_BANKS);

    logic [3*CW-1:0] shadow [NUM_BANKS][DEPTH];
    logic [3*CW-1:0] active [NUM_BANKS][DEPTH];
    logic            wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_bank} < NB);

    // A write coinciding with commit is forwarded into active so the commit includes it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    shadow[b][i] <= RST_RGB;
                    active[b][i] <= RST_RGB;
                end
            end
            pending <= 1'b0;
        end else begin
            if (commit) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        active[b][i] <= shadow[b][i];
                    end
                end
            end
            if (wr_ok) begin
                shadow[wr_bank][wr_index] <= wr_rgb;
                if (commit) begin
                    active[wr_bank][wr_index] <= wr_rgb;
                end
            end
            if (commit) begin
                pending <= 1'b0;
            end else if (wr_ok) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_hit = ({1'b0, rd_bank} < NB);
        rd_rgb = RST_RGB;
        if (rd_hit) begin
            rd_rgb = active[rd_bank][rd_index];
        end
    end

endmodule

// File: rtl/palette_lut.sv
// Two-stage palette lookup over a double-buffered bank store.
// Optional PALETTE_FADE_EN adds a fade_lvl input that scales each component in stage 2.
module palette_lut
    import palette_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int NUM_BANKS = 4,
    parameter int CW = PAL_CW,
    parameter logic [3*CW-1:0] RST_RGB = PAL_RST_RGB,
    parameter int TRANSP_IDX = PAL_TRANSP_IDX,
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
`ifdef PALETTE_FADE_EN
    input  logic [3:0]       fade_lvl,
`endif
    input  logic             pix_valid,
    input  logic [BW-1:0]    pix_bank,
    input  logic [IDX_W-1:0] pix_index,
    input  logic             wr_en,
    input  logic [BW-1:0]    wr_bank,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [3*CW-1:0]  wr_rgb,
    input  logic             commit,
    output logic             out_valid,
    output logic [CW-1:0]    red,
    output logic [CW-1:0]    green,
    output logic [CW-1:0]    blue,
    output logic             transparent,
    output logic             pending
);

    logic             vld_p1;
    logic [BW-1:0]    bank_p1;
    logic [IDX_W-1:0] index_p1;
    logic             vld_p2;
    logic [3*CW-1:0]  rgb_p2;
    logic             transp_p2;
    logic [3*CW-1:0]  rd_rgb;
    logic             rd_hit;
    logic [3*CW-1:0]  rgb_fade;

    palette_bank_store #(
        .IDX_W     (IDX_W),
        .NUM_BANKS (NUM_BANKS),
        .CW        (CW),
        .RST_RGB   (RST_RGB),
        .BW        (BW)
    ) u_store (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .wr_index (wr_index),
        .wr_rgb   (wr_rgb),
        .commit   (commit),
        .rd_bank  (bank_p1),
        .rd_index (index_p1),
        .rd_rgb   (rd_rgb),
        .rd_hit   (rd_hit),
        .pending  (pending)
    );

`ifdef PALETTE_FADE_EN
    function automatic logic [CW-1:0] fade_c(input logic [CW-1:0] c, input logic [3:0] lvl);
        logic [CW+4:0] prod;
        prod = (CW+5)'(c) * (CW+5)'({1'b0, lvl} + 5'd1);
        return prod[CW+3:4];
    endfunction

    assign rgb_fade = {fade_c(rd_rgb[3*CW-1:2*CW], fade_lvl),
                       fade_c(rd_rgb[2*CW-1:CW],   fade_lvl),
                       fade_c(rd_rgb[CW-1:0],      fade_lvl)};
`else
    assign rgb_fade = rd_rgb;
`endif

    // Stage 1: capture request
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= pix_valid;
        end
    end

    always_ff @(posedge Clk) begin
        bank_p1  <= pix_bank;
        index_p1 <= pix_index;
    end

    // Stage 2: register active-table read; colour and flag hold while idle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p2    <= 1'b0;
            rgb_p2    <= RST_RGB;
            transp_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                rgb_p2    <= rgb_fade;
                transp_p2 <= rd_hit && (index_p1 == IDX_W'(TRANSP_IDX));
            end
        end
    end

    assign out_valid   = vld_p2;
    assign red         = rgb_p2[3*CW-1:2*CW];
    assign green       = rgb_p2[2*CW-1:CW];
    assign blue        = rgb_p2[CW-1:0];
    assign transparent = transp_p2;

endmodule

// File: tb/tb_palette_lut.sv
// Directed, table-driven bench for palette_lut built with three banks so bank 3 is out of range.
module tb_palette_lut;
    import palette_pkg::*;

    localparam int IDX_W = 4;
    localparam int NUM_BANKS = 3;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [3:0]  fade_lvl;
    logic        pix_valid;
    logic [1:0]  pix_bank;
    logic [3:0]  pix_index;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        commit;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        pending;

    int checks = 0;
    int failures = 0;

    palette_lut #(.IDX_W(IDX_W), .NUM_BANKS(NUM_BANKS)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
`ifdef PALETTE_FADE_EN
        .fade_lvl    (fade_lvl),
`endif
        .pix_valid   (pix_valid),
        .pix_bank    (pix_bank),
        .pix_index   (pix_index),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_index    (wr_index),
        .wr_rgb      (wr_rgb),
        .commit      (commit),
        .out_valid   (out_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .transparent (transparent),
        .pending     (pending)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=done");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0]  bank;
        logic [3:0]  index;
        logic [11:0] exp_rgb;
        logic        exp_transp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [11:0] cur_rgb();
        rgb_t r;
        r.red = red;
        r.green = green;
        r.blue = blue;
        return r;
    endfunction

    task automatic wr(input logic [1:0] b, input logic [3:0] i, input logic [11:0] v, input logic cm);
        wr_en = 1'b1; wr_bank = b; wr_index = i; wr_rgb = v; commit = cm;
        step();
        wr_en = 1'b0; commit = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic lookup(input string name, input logic [1:0] b, input logic [3:0] i,
                          input logic [11:0] exp_rgb, input logic exp_t);
        pix_valid = 1'b1; pix_bank = b; pix_index = i;
        step();
        pix_valid = 1'b0;
        check({name, "_t1_valid"}, {31'd0, out_valid}, 32'd0);
        step();
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_rgb"}, {20'd0, cur_rgb()}, {20'd0, exp_rgb});
        check({name, "_transp"}, {31'd0, transparent}, {31'd0, exp_t});
    endtask

    initial begin
        int seen;
        Reset_n = 1'b0;
        fade_lvl = 4'd15;
        pix_valid = 1'b0; pix_bank = '0; pix_index = '0;
        wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_rgb = '0; commit = 1'b0;

        vecs[0] = '{2'd0, 4'd0, 12'h6AF, 1'b1};
        vecs[1] = '{2'd0, 4'd2, 12'h456, 1'b0};
        vecs[2] = '{2'd0, 4'd3, 12'h789, 1'b0};
        vecs[3] = '{2'd1, 4'd3, 12'h520, 1'b0};
        vecs[4] = '{2'd2, 4'd2, 12'h940, 1'b0};
        vecs[5] = '{2'd2, 4'd0, 12'h6AF, 1'b1};
        vecs[6] = '{2'd3, 4'd0, 12'h6AF, 1'b0};
        vecs[7] = '{2'd3, 4'd4, 12'h6AF, 1'b0};
        vecs[8] = '{2'd1, 4'd0, 12'h6AF, 1'b1};
        vecs[9] = '{2'd0, 4'd1, 12'h123, 1'b0};

        repeat (2) @(posedge Clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_rgb", {20'd0, cur_rgb()}, 32'h6AF);
        check("rst_transp", {31'd0, transparent}, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd0);
        #3 Reset_n = 1'b1;
        step();

        lookup("b0i5", 2'd0, 4'd5, 12'h6AF, 1'b0);

        wr(2'd1, 4'd3, 12'h520, 1'b0);
        check("wr_pending", {31'd0, pending}, 32'd1);
        lookup("pre_commit", 2'd1, 4'd3, 12'h6AF, 1'b0);
        check("pre_commit_pending", {31'd0, pending}, 32'd1);
        do_commit();
        check("commit_pending", {31'd0, pending}, 32'd0);
        lookup("post_commit", 2'd1, 4'd3, 12'h520, 1'b0);

        wr(2'd2, 4'd2, 12'h940, 1'b1);
        check("wrcommit_pending", {31'd0, pending}, 32'd0);
        lookup("wrcommit", 2'd2, 4'd2, 12'h940, 1'b0);

        wr(2'd3, 4'd4, 12'hFFF, 1'b0);
        check("oor_wr_pending0", {31'd0, pending}, 32'd0);
        wr(2'd0, 4'd1, 12'h123, 1'b0);
        wr(2'd0, 4'd2, 12'h456, 1'b0);
        wr(2'd0, 4'd3, 12'h789, 1'b0);
        wr(2'd3, 4'd1, 12'hEEE, 1'b0);
        check("oor_wr_pending1", {31'd0, pending}, 32'd1);
        do_commit();

        // Back-to-back stream: result for vector c-1 appears after the edge ending vector c.
        for (int c = 0; c <= 10; c++) begin
            if (c < 10) begin
                pix_valid = 1'b1; pix_bank = vecs[c].bank; pix_index = vecs[c].index;
            end else begin
                pix_valid = 1'b0;
            end
            step();
            if (c == 0) begin
                check("stream_lead_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                check($sformatf("stream%0d_valid", c-1), {31'd0, out_valid}, 32'd1);
                check($sformatf("stream%0d_rgb", c-1), {20'd0, cur_rgb()}, {20'd0, vecs[c-1].exp_rgb});
                check($sformatf("stream%0d_transp", c-1), {31'd0, transparent}, {31'd0, vecs[c-1].exp_transp});
            end
        end
        step();
        check("hold_valid", {31'd0, out_valid}, 32'd0);
        check("hold_rgb", {20'd0, cur_rgb()}, 32'h123);
        check("hold_transp", {31'd0, transparent}, 32'd0);

        do_commit();
        check("idle_commit_pending", {31'd0, pending}, 32'd0);
        lookup("idle_commit", 2'd0, 4'd2, 12'h456, 1'b0);

`ifdef PALETTE_FADE_EN
        wr(2'd0, 4'd6, 12'hFFF, 1'b1);
        fade_lvl = 4'd7;
        lookup("fade7", 2'd0, 4'd6, 12'h777, 1'b0);
        fade_lvl = 4'd15;
        lookup("fade15", 2'd0, 4'd6, 12'hFFF, 1'b0);
`endif

        // Reset with two requests in flight, shadow holding an uncommitted write.
        wr(2'd1, 4'd1, 12'hDDD, 1'b0);
        pix_valid = 1'b1; pix_bank = 2'd0; pix_index = 4'd1;
        step();
        pix_bank = 2'd0; pix_index = 4'd3;
        #2 Reset_n = 1'b0;
        #1 pix_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (out_valid) seen++;
        end
        #3 Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (out_valid) seen++;
        end
        check("flush_no_valid", seen, 0);
        check("flush_pending", {31'd0, pending}, 32'd0);
        check("flush_rgb", {20'd0, cur_rgb()}, 32'h6AF);
        check("flush_transp", {31'd0, transparent}, 32'd0);
        lookup("rst_b0i1", 2'd0, 4'd1, 12'h6AF, 1'b0);
        lookup("rst_b1i3", 2'd1, 4'd3, 12'h6AF, 1'b0);
        do_commit();
        lookup("rst_shadow_b1i1", 2'd1, 4'd1, 12'h6AF, 1'b0);
        lookup("rst_shadow_b2i2", 2'd2, 4'd2, 12'h6AF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
